gf2m_trinomial_reducer: RTL

- Digit-serial modular reducer for GF(2^M) with trinomial modulus f(x) = x^M + x^K + 1. Default is the B-409 field: x^409 + x^87 + 1.
- Consumes the 2M-bit carry-less product produced by the two-way Karatsuba multiplier.
- Returns the M-bit field element, so it sits directly downstream of the multiplier.
- Uses a valid/ready handshake on both sides and processes one operand at a time.

---
 rtl/gf2m_trinomial_reducer_if.sv | 22 ++
 rtl/gf2m_trinomial_reducer.sv | 82 ++++++++
 2 files changed

// File: rtl/gf2m_trinomial_reducer_if.sv
// gf2m_trinomial_reducer_if: operand-in / result-out handshake bundle for the GF(2^M) reducer.
interface gf2m_trinomial_reducer_if #(
    parameter int M = 409
);
    logic           in_valid;
    logic           in_ready;
    logic [2*M-1:0] c_in;
    logic           out_valid;
    logic           out_ready;
    logic [M-1:0]   r_out;
    logic           busy;

    modport master (
        output in_valid, c_in, out_ready,
        input  in_ready, out_valid, r_out, busy
    );

    modport slave (
        input  in_valid, c_in, out_ready,
        output in_ready, out_valid, r_out, busy
    );
endinterface

// File: rtl/gf2m_trinomial_reducer.sv
// gf2m_trinomial_reducer: digit-serial reduction of a 2M-bit product modulo x^M + x^K + 1.
// Define GF_REDUCE_ONESHOT_EN for two whole-width folds instead of M/DIGIT digit folds.
module gf2m_trinomial_reducer #(
    parameter int M     = 409,
    parameter int K     = 87,
    parameter int DIGIT = 32
) (
    input logic clk,
    input logic rst,
    gf2m_trinomial_reducer_if.slave bus
);
    localparam int W  = 2 * M;
    localparam int TW = $clog2(W);
    localparam logic [TW-1:0] MT = TW'(M);
    localparam logic [1:0] IDLE = 2'd0, REDUCE = 2'd1, DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  acc_q, acc_d, fold;
    logic [TW-1:0] top_q, top_d, top_nxt;
    logic [M-1:0]  r_q, r_d;
    logic          last;

`ifdef GF_REDUCE_ONESHOT_EN
    if (2 * K > M) begin : g_bad_k
        $error("one-shot reduction needs 2K <= M");
    end
    logic [W-1:0] h;
    // top_q doubles as the fold counter: 2M-1 on the first fold, M on the second
    assign h       = {{M{1'b0}}, acc_q[W-1:M]};
    assign fold    = {{M{1'b0}}, acc_q[M-1:0]} ^ h ^ (h << K);
    assign last    = top_q == MT;
    assign top_nxt = MT;
`else
    localparam logic [TW-1:0] DM1 = TW'(DIGIT - 1);
    logic [TW-1:0] lo;
    logic [W-1:0]  sv;
    // bits above top are already zero, so masking from lo upward isolates acc[top:lo]
    assign lo      = (top_q >= MT + DM1) ? top_q - DM1 : MT;
    assign sv      = acc_q & ({W{1'b1}} << lo);
    assign fold    = (acc_q & ~sv) ^ (sv >> M) ^ (sv >> (M - K));
    assign last    = lo == MT;
    assign top_nxt = lo - TW'(1);
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        top_d   = top_q;
        r_d     = r_q;
        if (state_q == IDLE && bus.in_valid) begin
            acc_d   = bus.c_in;
            top_d   = TW'(W - 1);
            state_d = REDUCE;
        end else if (state_q == REDUCE) begin
            acc_d   = fold;
            top_d   = top_nxt;
            state_d = last ? DONE : REDUCE;
            r_d     = last ? fold[M-1:0] : r_q;
        end else if (state_q == DONE && bus.out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            top_q   <= TW'(W - 1);
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            top_q   <= top_d;
            r_q     <= r_d;
        end
    end

    assign bus.in_ready  = state_q == IDLE;
    assign bus.busy      = state_q == REDUCE;
    assign bus.out_valid = state_q == DONE;
    assign bus.r_out     = r_q;
endmodule
